// File: rtl/jserial_alu.sv
// jserial_alu: bit-serial N-bit unsigned adder / magnitude comparator.
// One jadd cell and one jcmp cell are reused once per clock. The carry
// and the eq/al chain state live in flip-flops. A start/busy/done
// handshake sequences each operation.
module jserial_alu #(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic         wclk,
  input  logic         wreset,
  input  logic         wstart,
  input  logic         wop,
  input  logic [N-1:0] wa,
  input  logic [N-1:0] wb,
  input  logic         wci,
  output logic         wbusy,
  output logic         wdone,
  output logic [N-1:0] wc,
  output logic         wco,
  output logic         weq,
  output logic         wal
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    next_state;

  // Operands and serial state captured on an accepted start
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic          op_r;
  logic          carry_r;
  logic          eq_r;
  logic          al_r;
  logic [CW-1:0] k_r;

  // Per-cycle decode and cell outputs
  logic          accept;
  logic          last;
  logic [CW-1:0] idx;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic          a_bit;
  logic          b_bit;
  logic          add_sum;
  logic          add_cout;
  logic          cmp_c;
  logic          cmp_eqo;
  logic          cmp_alo;
  logic          cell_c;
  logic [N-1:0]  bit_mask;
  logic [N-1:0]  wc_next;

  // State register with synchronous reset
  always_ff @(posedge wclk) begin
    if (wreset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: DONE accepts a new start just like IDLE
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (wstart) next_state = RUN;
        else        next_state = IDLE;
      end
      RUN: begin
        if (last) next_state = DONE;
        else      next_state = RUN;
      end
      DONE: begin
        if (wstart) next_state = RUN;
        else        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Decode plus the shared jadd/jcmp cells on the currently selected bit
  always_comb begin
    accept   = 1'b0;
    last     = 1'b0;
    if ((state == IDLE) || (state == DONE)) begin
      accept = wstart;
    end else begin
      accept = 1'b0;
    end
    if ((state == RUN) && (k_r == CW'(N - 1))) begin
      last = 1'b1;
    end else begin
      last = 1'b0;
    end

    // Add walks LSB first, compare walks MSB first
    if (op_r) begin
      idx = CW'(N - 1) - k_r;
    end else begin
      idx = k_r;
    end
    a_sh  = a_r >> idx;
    b_sh  = b_r >> idx;
    a_bit = a_sh[0];
    b_bit = b_sh[0];

    // jadd cell: full adder
    add_sum  = a_bit ^ b_bit ^ carry_r;
    add_cout = (a_bit & b_bit) | (a_bit & carry_r) | (b_bit & carry_r);

    // jcmp cell: once a higher bit differs, eq drops and al is frozen
    cmp_c   = a_bit ^ b_bit;
    cmp_eqo = eq_r & ~cmp_c;
    cmp_alo = al_r | (eq_r & a_bit & ~b_bit);

    if (op_r) begin
      cell_c = cmp_c;
    end else begin
      cell_c = add_sum;
    end

    bit_mask = {{(N - 1){1'b0}}, 1'b1} << idx;
    wc_next  = (wc & ~bit_mask) | (bit_mask & {N{cell_c}});
  end

  // Datapath and registered outputs; reset abandons any operation in flight
  always_ff @(posedge wclk) begin
    if (wreset) begin
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= 1'b0;
      carry_r <= 1'b0;
      eq_r    <= 1'b0;
      al_r    <= 1'b0;
      k_r     <= '0;
      wbusy   <= 1'b0;
      wdone   <= 1'b0;
      wc      <= '0;
      wco     <= 1'b0;
      weq     <= 1'b0;
      wal     <= 1'b0;
    end else begin
      wdone <= 1'b0;
      if (accept) begin
        a_r     <= wa;
        b_r     <= wb;
        op_r    <= wop;
        carry_r <= wci;
        eq_r    <= 1'b1;
        al_r    <= 1'b0;
        k_r     <= '0;
        wbusy   <= 1'b1;
        wc      <= '0;
        wco     <= 1'b0;
        weq     <= 1'b0;
        wal     <= 1'b0;
      end else if (state == RUN) begin
        wc <= wc_next;
        if (op_r) begin
          eq_r <= cmp_eqo;
          al_r <= cmp_alo;
        end else begin
          carry_r <= add_cout;
        end
        if (last) begin
          wbusy <= 1'b0;
          wdone <= 1'b1;
          if (op_r) begin
            wco <= 1'b0;
            weq <= cmp_eqo;
            wal <= cmp_alo;
          end else begin
            wco <= add_cout;
            weq <= 1'b0;
            wal <= 1'b0;
          end
        end else begin
          k_r <= k_r + CW'(1);
        end
      end
    end
  end

endmodule
